// File: rtl/memu_if.sv
// EXE->MEM->WB handshake and data bundle for the memory-access stage.
// The stage uses the slave modport; its environment uses the master modport.
interface memu_if;
    logic        flush;
    logic        mem_allowin;
    logic        exe_to_mem_valid;
    logic [91:0] exe_to_mem_zip;
    logic [31:0] data_sram_rdata;
    logic        wb_allowin;
    logic        mem_to_wb_valid;
    logic [86:0] mem_to_wb_zip;
    logic [37:0] mem_rf_zip;
    logic        mem_ex_out;

    modport slave (
        input  flush, exe_to_mem_valid, exe_to_mem_zip, data_sram_rdata, wb_allowin,
        output mem_allowin, mem_to_wb_valid, mem_to_wb_zip, mem_rf_zip, mem_ex_out
    );

    modport master (
        output flush, exe_to_mem_valid, exe_to_mem_zip, data_sram_rdata, wb_allowin,
        input  mem_allowin, mem_to_wb_valid, mem_to_wb_zip, mem_rf_zip, mem_ex_out
    );
endinterface

// File: rtl/memu.sv
// Memory-access stage: aligns/extends returning SRAM load data and holds it
// across WB back-pressure, since EXE may reuse the SRAM while MEM is stalled.
module memu (
    input  logic  clk,
    input  logic  resetn,
    memu_if.slave bus
);
    typedef struct packed {
        logic        res_from_mem;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] alu_result;
        logic [3:0]  mem_op;
        logic [31:0] pc;
        logic        ex_valid;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic        is_ertn;
    } exe_zip_t;

    logic        mem_valid_q, mem_valid_d;
    exe_zip_t    zip_q, zip_d;
    logic        hold_vld_q, hold_vld_d;
    logic [31:0] rdata_hold_q, rdata_hold_d;

    logic        load_en;
    logic        mem_allowin;
    logic [31:0] ld_src;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] final_result;
    logic        out_rf_we;
    logic        unused_ok;

    assign mem_allowin = ~mem_valid_q | bus.wb_allowin;
    assign load_en     = bus.exe_to_mem_valid & mem_allowin;

    always_comb begin
        mem_valid_d  = mem_valid_q;
        zip_d        = zip_q;
        hold_vld_d   = hold_vld_q;
        rdata_hold_d = rdata_hold_q;

        if (bus.flush)
            mem_valid_d = 1'b0;
        else if (load_en)
            mem_valid_d = 1'b1;
        else if (mem_valid_q & bus.wb_allowin)
            mem_valid_d = 1'b0;

        if (load_en)
            zip_d = exe_zip_t'(bus.exe_to_mem_zip);

        // Capture only on the entry's first cycle: hold_vld is still clear then,
        // and stays set for the remaining stall cycles.
        if (load_en | bus.flush) begin
            hold_vld_d = 1'b0;
        end else if (mem_valid_q & ~hold_vld_q & zip_q.res_from_mem & ~bus.wb_allowin) begin
            hold_vld_d   = 1'b1;
            rdata_hold_d = bus.data_sram_rdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid_q  <= 1'b0;
            zip_q        <= '0;
            hold_vld_q   <= 1'b0;
            rdata_hold_q <= '0;
        end else begin
            mem_valid_q  <= mem_valid_d;
            zip_q        <= zip_d;
            hold_vld_q   <= hold_vld_d;
            rdata_hold_q <= rdata_hold_d;
        end
    end

    assign ld_src = hold_vld_q ? rdata_hold_q : bus.data_sram_rdata;

    always_comb begin
        ld_byte = ld_src[7:0];
        case (zip_q.alu_result[1:0])
            2'd0:    ld_byte = ld_src[7:0];
            2'd1:    ld_byte = ld_src[15:8];
            2'd2:    ld_byte = ld_src[23:16];
            default: ld_byte = ld_src[31:24];
        endcase
        ld_half = zip_q.alu_result[1] ? ld_src[31:16] : ld_src[15:0];

        // mem_op[3] selects zero extension for ld.bu / ld.hu
        ld_data = ld_src;
        case (zip_q.mem_op[1:0])
            2'd0:    ld_data = {{24{~zip_q.mem_op[3] & ld_byte[7]}}, ld_byte};
            2'd1:    ld_data = {{16{~zip_q.mem_op[3] & ld_half[15]}}, ld_half};
            default: ld_data = ld_src;
        endcase
    end

    assign final_result = zip_q.res_from_mem ? ld_data : zip_q.alu_result;
    assign out_rf_we    = mem_valid_q & zip_q.rf_we & ~zip_q.ex_valid & ~zip_q.is_ertn;

    assign bus.mem_allowin     = mem_allowin;
    assign bus.mem_to_wb_valid = mem_valid_q;
    assign bus.mem_to_wb_zip   = {out_rf_we, zip_q.rf_waddr, final_result, zip_q.pc,
                                  zip_q.ex_valid, zip_q.ecode, zip_q.esubcode, zip_q.is_ertn};
    assign bus.mem_rf_zip      = {out_rf_we, zip_q.rf_waddr, final_result};
    assign bus.mem_ex_out      = mem_valid_q & (zip_q.ex_valid | zip_q.is_ertn);

    // Store-kind bit is irrelevant at this stage
    assign unused_ok = zip_q.mem_op[2];
endmodule

// File: tb/tb_memu.sv
// Directed scoreboard bench for the memory-access stage.
module tb_memu;
    logic clk;
    logic resetn;
    memu_if bus();

    memu dut (.clk(clk), .resetn(resetn), .bus(bus.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    logic [86:0] sb_q[$];

    function automatic logic [91:0] exe(input logic rfm, input logic we, input logic [4:0] wa,
                                        input logic [31:0] alu, input logic [3:0] op,
                                        input logic [31:0] pc, input logic exv,
                                        input logic [5:0] ec, input logic [8:0] esub,
                                        input logic ertn);
        return {rfm, we, wa, alu, op, pc, exv, ec, esub, ertn};
    endfunction

    function automatic logic [86:0] wbz(input logic we, input logic [4:0] wa,
                                        input logic [31:0] res, input logic [31:0] pc,
                                        input logic exv, input logic [5:0] ec,
                                        input logic [8:0] esub, input logic ertn);
        return {we, wa, res, pc, exv, ec, esub, ertn};
    endfunction

    task automatic chk(input string tag, input logic [91:0] obs, input logic [91:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [91:0] z, input logic push, input logic [86:0] e);
        bus.exe_to_mem_valid = 1'b1;
        bus.exe_to_mem_zip   = z;
        if (push) sb_q.push_back(e);
    endtask

    // Compares the presented WB/forward bundles with the scoreboard head;
    // pops only when WB actually takes the entry.
    task automatic pop_chk(input string tag);
        logic [86:0] e;
        #1;
        n_assert++;
        assert (sb_q.size() > 0) else begin
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end
        if (sb_q.size() > 0) begin
            e = sb_q[0];
            chk({tag, ".valid"}, 92'(bus.mem_to_wb_valid), 92'(1'b1));
            chk({tag, ".zip"},   92'(bus.mem_to_wb_zip),   92'(e));
            chk({tag, ".fwd"},   92'(bus.mem_rf_zip),      92'(e[86:49]));
            if (bus.wb_allowin) void'(sb_q.pop_front());
        end
    endtask

    task automatic chk_idle(input string tag);
        #1;
        chk({tag, ".valid"}, 92'(bus.mem_to_wb_valid), 92'(1'b0));
        chk({tag, ".fwd_we"}, 92'(bus.mem_rf_zip[37]), 92'(1'b0));
        chk({tag, ".ex_out"}, 92'(bus.mem_ex_out), 92'(1'b0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] PC0 = 32'h1c00_0000;

    initial begin
        resetn               = 1'b0;
        bus.flush            = 1'b0;
        bus.exe_to_mem_valid = 1'b0;
        bus.exe_to_mem_zip   = '0;
        bus.data_sram_rdata  = '0;
        bus.wb_allowin       = 1'b1;
        @(negedge clk);
        chk_idle("reset");
        chk("reset.allowin", 92'(bus.mem_allowin), 92'(1'b1));
        step();
        resetn = 1'b1;
        step();

        // ld.b, byte 3 of 0x80FF1234 -> sign-extended 0x80
        issue(exe(1, 1, 5'd3, 32'h1000_0003, 4'd0, PC0, 0, 0, 0, 0), 1,
              wbz(1, 5'd3, 32'hFFFF_FF80, PC0, 0, 0, 0, 0));
        step();
        bus.exe_to_mem_valid = 1'b0;
        bus.data_sram_rdata  = 32'h80FF_1234;
        pop_chk("ldb");
        step();
        chk_idle("ldb.one_cycle");

        // ld.hu / ld.h / ld.w pipelined back to back
        issue(exe(1, 1, 5'd4, 32'h1000_0002, 4'd9, PC0 + 4, 0, 0, 0, 0), 1,
              wbz(1, 5'd4, 32'h0000_80FF, PC0 + 4, 0, 0, 0, 0));
        step();
        issue(exe(1, 1, 5'd5, 32'h1000_0002, 4'd1, PC0 + 8, 0, 0, 0, 0), 1,
              wbz(1, 5'd5, 32'hFFFF_80FF, PC0 + 8, 0, 0, 0, 0));
        pop_chk("ldhu");
        step();
        issue(exe(1, 1, 5'd6, 32'h1000_0000, 4'd2, PC0 + 12, 0, 0, 0, 0), 1,
              wbz(1, 5'd6, 32'h80FF_1234, PC0 + 12, 0, 0, 0, 0));
        pop_chk("ldh");
        step();
        bus.exe_to_mem_valid = 1'b0;
        pop_chk("ldw");
        step();

        // Stalled ld.w: SRAM data changes after the first cycle, result must not
        bus.wb_allowin = 1'b0;
        issue(exe(1, 1, 5'd7, 32'h2000_0000, 4'd2, PC0 + 16, 0, 0, 0, 0), 1,
              wbz(1, 5'd7, 32'h1122_3344, PC0 + 16, 0, 0, 0, 0));
        step();
        bus.exe_to_mem_valid = 1'b0;
        bus.data_sram_rdata  = 32'h1122_3344;
        pop_chk("stall.c1");
        chk("stall.c1.allowin", 92'(bus.mem_allowin), 92'(1'b0));
        step();
        bus.data_sram_rdata = 32'hDEAD_BEEF;
        pop_chk("stall.c2");
        chk("stall.c2.allowin", 92'(bus.mem_allowin), 92'(1'b0));
        step();
        pop_chk("stall.c3");
        step();
        // Release; a new ld.b enters at the same edge and must use live data
        bus.wb_allowin = 1'b1;
        issue(exe(1, 1, 5'd8, 32'h2000_0001, 4'd0, PC0 + 20, 0, 0, 0, 0), 1,
              wbz(1, 5'd8, 32'h0000_007F, PC0 + 20, 0, 0, 0, 0));
        pop_chk("stall.release");
        chk("stall.release.allowin", 92'(bus.mem_allowin), 92'(1'b1));
        step();
        bus.exe_to_mem_valid = 1'b0;
        bus.data_sram_rdata  = 32'h0000_7F00;
        pop_chk("after_stall.live");
        step();
        chk_idle("after_stall.idle");

        // Exception pass-through
        issue(exe(0, 1, 5'd9, 32'h0000_1234, 4'd0, PC0 + 24, 1, 6'h0B, 9'h1A5, 0), 1,
              wbz(0, 5'd9, 32'h0000_1234, PC0 + 24, 1, 6'h0B, 9'h1A5, 0));
        step();
        bus.exe_to_mem_valid = 1'b0;
        pop_chk("exc");
        chk("exc.ex_out", 92'(bus.mem_ex_out), 92'(1'b1));
        step();

        // Flush during a stalled load; simultaneous EXE entry must be dropped
        bus.wb_allowin = 1'b0;
        issue(exe(1, 1, 5'd10, 32'h3000_0000, 4'd2, PC0 + 28, 0, 0, 0, 0), 0, '0);
        step();
        bus.exe_to_mem_valid = 1'b0;
        #1;
        chk("flush.pre_valid", 92'(bus.mem_to_wb_valid), 92'(1'b1));
        step();
        bus.flush      = 1'b1;
        bus.wb_allowin = 1'b1;
        issue(exe(0, 1, 5'd11, 32'h0000_0099, 4'd0, PC0 + 32, 0, 0, 0, 0), 0, '0);
        step();
        bus.flush            = 1'b0;
        bus.exe_to_mem_valid = 1'b0;
        chk_idle("flush.next");
        step();
        chk_idle("flush.later");

        // add then ld.bu back to back
        issue(exe(0, 1, 5'd12, 32'h0000_0005, 4'd0, PC0 + 36, 0, 0, 0, 0), 1,
              wbz(1, 5'd12, 32'h0000_0005, PC0 + 36, 0, 0, 0, 0));
        step();
        issue(exe(1, 1, 5'd13, 32'h4000_0000, 4'd8, PC0 + 40, 0, 0, 0, 0), 1,
              wbz(1, 5'd13, 32'h0000_00F0, PC0 + 40, 0, 0, 0, 0));
        pop_chk("b2b.add");
        step();
        bus.exe_to_mem_valid = 1'b0;
        bus.data_sram_rdata  = 32'h0000_00F0;
        pop_chk("b2b.ldbu");
        step();

        // Asynchronous reset in the middle of a stall
        bus.wb_allowin = 1'b0;
        issue(exe(1, 1, 5'd14, 32'h5000_0000, 4'd2, PC0 + 44, 0, 0, 0, 0), 0, '0);
        step();
        bus.exe_to_mem_valid = 1'b0;
        #1;
        chk("arst.pre_valid", 92'(bus.mem_to_wb_valid), 92'(1'b1));
        resetn = 1'b0;
        chk_idle("arst.immediate");
        step();
        resetn         = 1'b1;
        bus.wb_allowin = 1'b1;
        step();
        chk_idle("arst.after");

        chk("scoreboard.drained", 92'(sb_q.size()), 92'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
